// File: rtl/kij_inst_sequencer.sv
// kij_inst_sequencer: walks every kernel index through weight load, kernel
// load, activation load, execute and output drain, emitting one core
// instruction word per cycle. Every output is registered, so inst reflects
// the decision made at the previous clock edge.
module kij_inst_sequencer #(
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int len_kij  = 9,
  parameter int len_nij  = 36,
  parameter int xaddr_bw = 11,
  parameter int paddr_bw = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [xaddr_bw-1:0] w_base,
  input  logic [xaddr_bw-1:0] a_base,
  input  logic                dbi_mode,
  input  logic                ofifo_valid,
  output logic [50:0]         inst,
  output logic                busy,
  output logic                done,
  output logic [3:0]          kij_idx
);

  // All SRAM chip/write enables deasserted (active-low), everything else 0.
  localparam logic [50:0] IDLE_INST = (51'd1 << 19) | (51'd1 << 18) |
                                      (51'd1 << 33) | (51'd1 << 32) |
                                      (51'd1 << 47) | (51'd1 << 46) |
                                      (51'd1 << 50) | (51'd1 << 49);

  // Longest in-state count: kernel load+flush or activation load.
  localparam int TMAX = (row + col > len_nij + 1) ? row + col : len_nij + 1;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int DW   = $clog2(len_nij + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WLD, S_KLD, S_ALD, S_EXE, S_WAIT, S_DRN, S_DONE
  } state_t;

  state_t              state;
  logic [TW-1:0]       t;
  logic [xaddr_bw-1:0] w_base_r;
  logic [xaddr_bw-1:0] a_base_r;
  logic                dbi_r;
  logic [DW-1:0]       rd_cnt;   // ofifo reads issued this kij
  logic [DW-1:0]       wr_cnt;   // psum writes issued this kij (d)
  logic                pend;     // a read was issued last cycle; write owed

  logic [xaddr_bw-1:0] w_tile;
  logic [paddr_bw-1:0] p_tile;
  logic [50:0]         run_idle;

  // Per-kij base addresses; wrap silently at the address width.
  assign w_tile   = w_base_r + xaddr_bw'(kij_idx) * xaddr_bw'(row);
  assign p_tile   = paddr_bw'(kij_idx) * paddr_bw'(len_nij);
  assign run_idle = IDLE_INST | {2'b0, dbi_r, 48'b0};

  // Phase sequencing and registered instruction generation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      t        <= '0;
      kij_idx  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      inst     <= IDLE_INST;
      w_base_r <= '0;
      a_base_r <= '0;
      dbi_r    <= 1'b0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      pend     <= 1'b0;
    end else begin
      done <= 1'b0;
      inst <= run_idle;
      case (state)
        S_IDLE: begin
          inst <= IDLE_INST;
          if (start) begin
            w_base_r <= w_base;
            a_base_r <= a_base;
            dbi_r    <= dbi_mode;
            kij_idx  <= '0;
            t        <= '0;
            busy     <= 1'b1;
            inst     <= IDLE_INST | {2'b0, dbi_mode, 48'b0};
            state    <= S_WLD;
          end
        end
        S_WLD: begin
          if (t < TW'(row)) begin
            inst[19]            <= 1'b0;
            inst[18]            <= 1'b1;
            inst[7 +: xaddr_bw] <= w_tile + xaddr_bw'(t);
          end
          // SRAM data lands one cycle after the read, so the L0 write lags.
          if (t != '0) inst[2] <= 1'b1;
          if (t == TW'(row)) begin
            t     <= '0;
            state <= S_KLD;
          end else t <= t + 1'b1;
        end
        S_KLD: begin
          if (t < TW'(row)) begin
            inst[3] <= 1'b1;
            inst[0] <= 1'b1;
          end
          if (t == TW'(row + col - 1)) begin
            t     <= '0;
            state <= S_ALD;
          end else t <= t + 1'b1;
        end
        S_ALD: begin
          if (t < TW'(len_nij)) begin
            inst[19]            <= 1'b0;
            inst[18]            <= 1'b1;
            inst[7 +: xaddr_bw] <= a_base_r + xaddr_bw'(t);
          end
          if (t != '0) inst[2] <= 1'b1;
          if (t == TW'(len_nij)) begin
            t     <= '0;
            state <= S_EXE;
          end else t <= t + 1'b1;
        end
        S_EXE: begin
          inst[3] <= 1'b1;
          inst[1] <= 1'b1;
          if (t == TW'(len_nij - 1)) begin
            t     <= '0;
            state <= S_WAIT;
          end else t <= t + 1'b1;
        end
        S_WAIT: begin
          if (ofifo_valid) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
            pend   <= 1'b0;
            state  <= S_DRN;
          end
        end
        S_DRN: begin
          if (ofifo_valid && rd_cnt != DW'(len_nij)) begin
            inst[6] <= 1'b1;
            rd_cnt  <= rd_cnt + 1'b1;
            pend    <= 1'b1;
          end else pend <= 1'b0;
          if (pend) begin
            inst[33]            <= 1'b0;
            inst[32]            <= 1'b0;
            inst[20 +: paddr_bw] <= p_tile + paddr_bw'(wr_cnt);
            wr_cnt              <= wr_cnt + 1'b1;
            if (wr_cnt == DW'(len_nij - 1)) begin
              if (kij_idx == 4'(len_kij - 1)) state <= S_DONE;
              else begin
                kij_idx <= kij_idx + 4'd1;
                t       <= '0;
                state   <= S_WLD;
              end
            end
          end
        end
        S_DONE: begin
          inst  <= IDLE_INST;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kij_inst_sequencer.sv
// Directed bench for kij_inst_sequencer: a full 9-kij instance and a
// single-kij instance share clock and reset, each with its own start and
// ofifo_valid.
module tb_kij_inst_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, start1, dbi_mode, ov, ov1;
  logic [10:0] w_base, a_base;
  logic [50:0] inst, inst1;
  logic        busy, busy1, done, done1;
  logic [3:0]  kij, kij1;

  int total = 0;
  int bad   = 0;

  localparam logic [50:0] IDLE_INST = (51'd1 << 19) | (51'd1 << 18) |
                                      (51'd1 << 33) | (51'd1 << 32) |
                                      (51'd1 << 47) | (51'd1 << 46) |
                                      (51'd1 << 50) | (51'd1 << 49);

  kij_inst_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .w_base(w_base), .a_base(a_base),
    .dbi_mode(dbi_mode), .ofifo_valid(ov), .inst(inst), .busy(busy),
    .done(done), .kij_idx(kij)
  );

  kij_inst_sequencer #(.len_kij(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .w_base(w_base), .a_base(a_base),
    .dbi_mode(dbi_mode), .ofifo_valid(ov1), .inst(inst1), .busy(busy1),
    .done(done1), .kij_idx(kij1)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [11:0] wq[$];
  logic [10:0] rq[$];
  int n, cnt, err, err2, last_wr;
  logic pulsed, prev, after_busy;
  logic [3:0] after_kij;

  initial begin
    reset = 1'b1; start = 1'b0; start1 = 1'b0; ov = 1'b0; ov1 = 1'b0;
    dbi_mode = 1'b0; w_base = '0; a_base = '0;
    repeat (3) tick;
    reset = 1'b0;

    // ---- reset state and idle hold ----
    chk("rst_inst", inst, IDLE_INST);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_kij", kij, 0);
    chk("rst_inst1", inst1, IDLE_INST);
    for (int i = 0; i < 20; i++) begin
      tick;
      chk("idle_inst", inst, IDLE_INST);
      chk("idle_busy", busy, 0);
    end

    // ---- single-kij run, ofifo_valid tied high ----
    w_base = 11'h100; a_base = 11'h000; dbi_mode = 1'b1; ov1 = 1'b1;
    start1 = 1'b1; tick; start1 = 1'b0;
    chk("s_busy", busy1, 1);
    chk("s_kij", kij1, 0);
    n = 0;
    while (inst1[19] !== 1'b0 && n < 20) begin tick; n++; end
    chk("s_wld_found", n < 20, 1);
    for (int k = 0; k < 10; k++) begin
      chk("s_wld_cen", inst1[19], (k < 8) ? 1'b0 : 1'b1);
      if (k < 8) begin
        chk("s_wld_wen", inst1[18], 1);
        chk("s_wld_addr", inst1[17:7], 11'h100 + 11'(k));
      end
      chk("s_l0_wr", inst1[2], (k >= 1 && k <= 8) ? 1'b1 : 1'b0);
      tick;
    end
    wq.delete(); err = 0; err2 = 0; n = 0;
    while (done1 !== 1'b1 && n < 400) begin
      if (busy1 && inst1[48] !== 1'b1) err++;
      if (inst1[33] === 1'b0) begin
        wq.push_back(inst1[31:20]);
        if (inst1[32] !== 1'b0) err2++;
      end
      tick; n++;
    end
    chk("s_done_seen", n < 400, 1);
    chk("s_busy_at_done", busy1, 0);
    chk("s_dbi", err, 0);
    chk("s_pwen", err2, 0);
    chk("s_nwr", wq.size(), 36);
    cnt = 0;
    for (int i = 0; i < wq.size(); i++) if (wq[i] !== 12'(i)) cnt++;
    chk("s_wr_order", cnt, 0);
    cnt = 1;
    repeat (5) begin tick; if (done1) cnt++; end
    chk("s_done_once", cnt, 1);

    // ---- full 9-kij run with a stray start during EXE ----
    w_base = 11'h010; a_base = 11'h200; dbi_mode = 1'b0; ov = 1'b1;
    start = 1'b1; tick; start = 1'b0;
    wq.delete(); rq.delete(); n = 0; pulsed = 1'b0;
    after_kij = '0; after_busy = 1'b0;
    while (done !== 1'b1 && n < 3000) begin
      if (inst[19] === 1'b0 && kij == 4'd4) rq.push_back(inst[17:7]);
      if (inst[33] === 1'b0) wq.push_back(inst[31:20]);
      start = (kij == 4'd2 && inst[1] === 1'b1 && !pulsed);
      if (start) begin pulsed = 1'b1; w_base = 11'h3F0; a_base = 11'h7FF; end
      tick; n++;
      if (start) begin start = 1'b0; after_kij = kij; after_busy = busy; end
    end
    chk("f_done_seen", n < 3000, 1);
    chk("f_pulsed", pulsed, 1);
    chk("f_ign_kij", after_kij, 2);
    chk("f_ign_busy", after_busy, 1);
    chk("f_kij_at_done", kij, 8);
    chk("f_busy_at_done", busy, 0);
    chk("f_nrd4", rq.size(), 44);
    if (rq.size() == 44) begin
      for (int i = 0; i < 8; i++) chk("f_k4_waddr", rq[i], 11'h030 + 11'(i));
      for (int i = 0; i < 36; i += 7) chk("f_k4_aaddr", rq[8 + i], 11'h200 + 11'(i));
    end
    chk("f_nwr", wq.size(), 324);
    if (wq.size() == 324)
      for (int i = 144; i < 180; i++) chk("f_k4_paddr", wq[i], 12'(i));
    cnt = 0;
    for (int i = 0; i < wq.size(); i++) if (wq[i] !== 12'(i)) cnt++;
    chk("f_wr_order", cnt, 0);

    // ---- drain with ofifo_valid toggling every cycle ----
    w_base = 11'h100; a_base = 11'h000; dbi_mode = 1'b1; ov1 = 1'b0;
    start1 = 1'b1; tick; start1 = 1'b0;
    wq.delete(); n = 0; err = 0; err2 = 0; cnt = 0; last_wr = -10;
    while (done1 !== 1'b1 && n < 600) begin
      ov1 = ~ov1;
      prev = ov1;
      tick; n++;
      if (inst1[6] === 1'b1) begin
        cnt++;
        if (!prev) err++;
      end
      if (inst1[33] === 1'b0) begin
        wq.push_back(inst1[31:20]);
        if (last_wr == n - 1) err2++;
        last_wr = n;
      end
    end
    chk("t_done_seen", n < 600, 1);
    chk("t_rd_when_invalid", err, 0);
    chk("t_nrd", cnt, 36);
    chk("t_back_to_back_wr", err2, 0);
    chk("t_nwr", wq.size(), 36);
    cnt = 0;
    for (int i = 0; i < wq.size(); i++) if (wq[i] !== 12'(i)) cnt++;
    chk("t_wr_order", cnt, 0);

    // ---- reset mid-drain, then restart from kij 0 ----
    ov = 1'b1; ov1 = 1'b0; w_base = 11'h010; a_base = 11'h200; dbi_mode = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    cnt = 0; n = 0;
    while (n < 600) begin
      tick; n++;
      if (inst[33] === 1'b0) cnt++;
      if (cnt == 46) break;
    end
    chk("r_reached", cnt, 46);
    chk("r_kij_before", kij, 1);
    reset = 1'b1; tick;
    chk("r_inst", inst, IDLE_INST);
    chk("r_busy", busy, 0);
    chk("r_done", done, 0);
    chk("r_kij", kij, 0);
    reset = 1'b0;
    cnt = 0;
    repeat (200) begin tick; if (done) cnt++; end
    chk("r_no_done", cnt, 0);
    start = 1'b1; tick; start = 1'b0;
    chk("r2_kij", kij, 0);
    chk("r2_busy", busy, 1);
    n = 0;
    while (inst[19] !== 1'b0 && n < 20) begin tick; n++; end
    chk("r2_wld_found", n < 20, 1);
    chk("r2_first_addr", inst[17:7], 11'h010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
